// File: rtl/silly_sweep_pkg.sv
// Shared types and sizes for the silly truth-table sweeper.
// Used by silly_sweep_ctrl and by anything that inspects its state.
package silly_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int DWELL_W = 4;

endpackage

// File: rtl/silly_sweep_ctrl_silly.sv
// The 3-input combinational silly block that the sweeper characterises.
// Its output is y = a ^ (b & c).
module silly (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = a ^ (b & c);

endmodule

// File: rtl/silly_sweep_ctrl.sv
// Sweeps all eight {a,b,c} vectors through silly, captures y into a truth table and checks it.
// Optional SILLY_SWEEP_MISMATCH_EN adds a per-sweep mismatch_cnt output.
module silly_sweep_ctrl
    import silly_sweep_pkg::*;
#(
    parameter int         DWELL    = 2,
    parameter logic [7:0] EXPECTED = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       table_q,
    output logic [VEC_W-1:0] vec_q
`ifdef SILLY_SWEEP_MISMATCH_EN
    ,
    output logic [3:0]       mismatch_cnt
`endif
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [VEC_W-1:0]   VEC_LAST   = VEC_W'(NUM_VEC - 1);

    sweep_state_t         state_q, state_d;
    logic [DWELL_W-1:0]   dwell_cnt_q;
    logic                 y;

    silly u_silly (
        .a (vec_q[2]),
        .b (vec_q[1]),
        .c (vec_q[0]),
        .y (y)
    );

    // abort beats start only while a sweep is running
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (abort) state_d = IDLE;
                     else if (dwell_cnt_q == DWELL_LAST) state_d = SAMPLE;
            SAMPLE:  if (abort) state_d = IDLE;
                     else if (vec_q == VEC_LAST) state_d = DONE;
                     else state_d = DRIVE;
            DONE:    if (start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dwell_cnt_q  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            table_q      <= '0;
            vec_q        <= '0;
`ifdef SILLY_SWEEP_MISMATCH_EN
            mismatch_cnt <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy    <= (state_d == DRIVE) || (state_d == SAMPLE);
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        vec_q        <= '0;
                        dwell_cnt_q  <= '0;
                        table_q      <= '0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
`ifdef SILLY_SWEEP_MISMATCH_EN
                        mismatch_cnt <= '0;
`endif
                    end else if (state_q == DONE) begin
                        done <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (!abort) begin
                        dwell_cnt_q <= (dwell_cnt_q == DWELL_LAST) ? '0
                                                                   : dwell_cnt_q + DWELL_W'(1);
                    end
                end
                SAMPLE: begin
                    if (!abort) begin
                        table_q[vec_q] <= y;
`ifdef SILLY_SWEEP_MISMATCH_EN
                        if (y != EXPECTED[vec_q]) mismatch_cnt <= mismatch_cnt + 4'd1;
`endif
                        // the last vector's y is not in table_q yet, so splice it in
                        if (vec_q == VEC_LAST) pass <= ({y, table_q[6:0]} == EXPECTED);
                        else                   vec_q <= vec_q + VEC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_silly_sweep_ctrl.sv
// Self-checking bench for silly_sweep_ctrl: one DUT with the golden table, one with its inverse.
// Honours SILLY_SWEEP_MISMATCH_EN when defined for the build.
module tb_silly_sweep_ctrl;
    import silly_sweep_pkg::*;

    function automatic logic silly_model(input logic a, input logic b, input logic c);
        return a ^ (b & c);
    endfunction

    function automatic logic [7:0] golden_tbl();
        logic [7:0] t;
        logic [2:0] v;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            v    = 3'(i);
            t[i] = silly_model(v[2], v[1], v[0]);
        end
        return t;
    endfunction

    localparam logic [7:0] GOLDEN = golden_tbl();

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic       busy, done, pass;
    logic [7:0] table_q;
    logic [2:0] vec_q;
    logic       busy_n, done_n, pass_n;
    logic [7:0] table_n;
    logic [2:0] vec_n;
`ifdef SILLY_SWEEP_MISMATCH_EN
    logic [3:0] mm_cnt, mm_cnt_n;
`endif

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    silly_sweep_ctrl #(.DWELL(2), .EXPECTED(GOLDEN)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .pass(pass), .table_q(table_q), .vec_q(vec_q)
`ifdef SILLY_SWEEP_MISMATCH_EN
        , .mismatch_cnt(mm_cnt)
`endif
    );

    silly_sweep_ctrl #(.DWELL(2), .EXPECTED(~GOLDEN)) dut_n (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy_n), .done(done_n), .pass(pass_n), .table_q(table_n), .vec_q(vec_n)
`ifdef SILLY_SWEEP_MISMATCH_EN
        , .mismatch_cnt(mm_cnt_n)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vec(input logic [2:0] v);
        int k;
        k = 0;
        while (vec_q !== v && k < 100) begin
            tick();
            k++;
        end
        n_cmp++;
        if (vec_q !== v) begin
            n_fail++;
            $display("FAIL wait_vec: got vec %0d required %0d within 100 cycles", vec_q, v);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: done=%b required 1 within 200 cycles", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, pass, table_q, vec_q} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {busy, done, pass, table_q, vec_q});
        end
        n_cmp++;
        if (dut.state_q !== IDLE || dut.dwell_cnt_q !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got state %0d dwell %0d required 0/0", dut.state_q, dut.dwell_cnt_q);
        end
`ifdef SILLY_SWEEP_MISMATCH_EN
        n_cmp++;
        if (mm_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mismatch_cnt: got %0d required 0", mm_cnt);
        end
`endif
        reset = 1'b0; start = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy %b state %0d required 0/IDLE", busy, dut.state_q);
        end
    endtask

    // spam=1 keeps start high through the busy window; it must have no effect
    task automatic run_sweep(input bit spam, input string name);
        logic [7:0] got, exp;
        int         v;
        start = 1'b1;
        tick();
        for (int n = 0; n <= 25; n++) begin
            v = (n / 3 > 7) ? 7 : n / 3;
            exp_q.push_back({3'b000, 1'(n >= 25), 1'(n < 24), 3'(v)});
        end
        for (int n = 0; n <= 25; n++) begin
            if (n > 0) tick();
            got = {3'b000, done, busy, vec_q};
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s_seq edge %0d: got done/busy/vec %h required %h", name, n, got, exp);
            end
            start = spam && (n < 23);
        end
        start = 1'b0;
        n_cmp++;
        if (table_q !== GOLDEN || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_result: got table %h pass %b required %h/1", name, table_q, pass, GOLDEN);
        end
        n_cmp++;
        if (table_n !== GOLDEN || pass_n !== 1'b0 || done_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_inverse: got table %h pass %b done %b required %h/0/1", name, table_n, pass_n, done_n, GOLDEN);
        end
`ifdef SILLY_SWEEP_MISMATCH_EN
        n_cmp++;
        if (mm_cnt !== 4'd0 || mm_cnt_n !== 4'd8) begin
            n_fail++;
            $display("FAIL %s_mismatch_cnt: got %0d/%0d required 0/8", name, mm_cnt, mm_cnt_n);
        end
`endif
    endtask

    task automatic test_sweep();
        run_sweep(1'b0, "sweep");
    endtask

    task automatic test_start_ignored();
        run_sweep(1'b1, "start_spam");
    endtask

    task automatic test_restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({done, busy, table_q, vec_q} !== {1'b0, 1'b1, 8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL restart_clear: got done %b busy %b table %h vec %0d required 0/1/00/0", done, busy, table_q, vec_q);
        end
        wait_done();
        n_cmp++;
        if (table_q !== GOLDEN || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_result: got table %h pass %b required %h/1", table_q, pass, GOLDEN);
        end
    endtask

    task automatic test_abort();
        logic [7:0] g;
        g = GOLDEN;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(3'd4);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        n_cmp++;
        if (dut.state_q !== IDLE || busy !== 1'b0 || done !== 1'b0 || vec_q !== 3'd4) begin
            n_fail++;
            $display("FAIL abort_state: got state %0d busy %b done %b vec %0d required IDLE/0/0/4", dut.state_q, busy, done, vec_q);
        end
        n_cmp++;
        if (table_q !== {4'h0, g[3:0]}) begin
            n_fail++;
            $display("FAIL abort_table: got %h required %h", table_q, {4'h0, g[3:0]});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (dut.state_q !== IDLE || table_q !== {4'h0, g[3:0]}) begin
            n_fail++;
            $display("FAIL abort_idle: got state %0d table %h required IDLE/%h", dut.state_q, table_q, {4'h0, g[3:0]});
        end
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || dut.state_q !== DRIVE || vec_q !== 3'd0 || table_q !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_start_idle: got busy %b state %0d vec %0d table %h required 1/DRIVE/0/00", busy, dut.state_q, vec_q, table_q);
        end
    endtask

    task automatic test_reset_mid();
        wait_vec(3'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, pass, table_q, vec_q} !== 14'h0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid: got %h state %0d required 0/IDLE", {busy, done, pass, table_q, vec_q}, dut.state_q);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        n_cmp++;
        if (table_q !== GOLDEN || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: got table %h pass %b required %h/1", table_q, pass, GOLDEN);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        test_reset();
        test_sweep();
        test_restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
